// File: rtl/mmu_host_arb_if.sv
// Bundles the cache-client request/response channel and the host bus for mmu_host_arb.
// The arbiter connects through the slave modport; clients and host models use master.
interface mmu_host_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int LINE_W  = 512
);
   logic [NUM_REQ-1:0]        req_rd;
   logic [NUM_REQ-1:0]        req_wr;
   logic [NUM_REQ*32-1:0]     req_addr;
   logic [NUM_REQ*LINE_W-1:0] req_wr_data;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_err;
   logic [LINE_W-1:0]         rsp_data;
   logic                      busy;
   logic                      host_init;
   logic                      host_rd_ready;
   logic                      host_wr_ready;
   logic [LINE_W-1:0]         host_data_bus_read_in;
   logic [LINE_W-1:0]         host_data_bus_write_out;
   logic [63:0]               cpu_addr;
   logic                      host_re;
   logic                      host_we;
   logic                      host_rgo;
   logic                      host_wgo;

   modport slave (
      input  req_rd, req_wr, req_addr, req_wr_data,
      input  host_init, host_rd_ready, host_wr_ready, host_data_bus_read_in,
      output gnt, rsp_valid, rsp_err, rsp_data, busy,
      output host_data_bus_write_out, cpu_addr, host_re, host_we, host_rgo, host_wgo
   );

   modport master (
      output req_rd, req_wr, req_addr, req_wr_data,
      output host_init, host_rd_ready, host_wr_ready, host_data_bus_read_in,
      input  gnt, rsp_valid, rsp_err, rsp_data, busy,
      input  host_data_bus_write_out, cpu_addr, host_re, host_we, host_rgo, host_wgo
   );
endinterface

// File: rtl/mmu_host_arb.sv
// Round-robin arbiter between NUM_REQ cache clients and the host memory bus:
// line fill and write-back, per-transaction timeout, registered response pulses.
module mmu_host_arb #(
   parameter int NUM_REQ        = 2,
   parameter int LINE_W         = 512,
   parameter int HOST_ADDR_BITS = 16,
   parameter int TIMEOUT        = 1024
) (
   input  logic          clk,
   input  logic          rst,
   mmu_host_arb_if.slave bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_READY   = 2'd1,
      ST_RD      = 2'd2,
      ST_WR      = 2'd3
   } state_t;

   state_t                    state_r, state_nx_s;
   logic [IDX_W-1:0]          rr_ptr_r, idx_r, win_idx_s;
   logic [CNT_W-1:0]          wait_cnt_r;
   logic [HOST_ADDR_BITS-1:0] addr_r, win_addr_s;
   logic [LINE_W-1:0]         wdata_r, win_wdata_s, rsp_data_r;
   logic [NUM_REQ-1:0]        elig_s, rsp_valid_r, rsp_err_r;
   logic                      win_found_s, win_wr_s;
   logic                      grab_s, done_s, tmo_s, host_re_s, host_we_s, in_xfer_s;
   int                        cand_s;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1'b1) << idx;
   endfunction

   // Round-robin scan: first eligible client at or after rr_ptr, wrapping.
   always_comb begin
      elig_s      = bus.req_rd | bus.req_wr;
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = (int'(rr_ptr_r) + i) % NUM_REQ;
         if (!win_found_s && elig_s[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = IDX_W'(cand_s);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Winner payload; a pending write-back takes precedence over a fill.
   always_comb begin
      win_addr_s  = '0;
      win_wdata_s = '0;
      win_wr_s    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (IDX_W'(k) == win_idx_s) begin
            win_addr_s  = bus.req_addr[k*32 +: HOST_ADDR_BITS];
            win_wdata_s = bus.req_wr_data[k*LINE_W +: LINE_W];
            win_wr_s    = bus.req_wr[k];
         end else begin
            win_wr_s = win_wr_s;
         end
      end
   end

   // Next-state and host strobe decode.
   always_comb begin
      state_nx_s = state_r;
      grab_s     = 1'b0;
      done_s     = 1'b0;
      tmo_s      = 1'b0;
      host_re_s  = 1'b0;
      host_we_s  = 1'b0;
      case (state_r)
         ST_STARTUP: begin
            if (bus.host_init) begin
               state_nx_s = ST_READY;
            end else begin
               state_nx_s = ST_STARTUP;
            end
         end
         ST_READY: begin
            if (win_found_s) begin
               grab_s     = 1'b1;
               state_nx_s = win_wr_s ? ST_WR : ST_RD;
            end else begin
               state_nx_s = ST_READY;
            end
         end
         ST_RD: begin
            if (bus.host_rd_ready) begin
               host_re_s  = 1'b1;
               done_s     = 1'b1;
               state_nx_s = ST_READY;
            end else if ((TIMEOUT > 0) && (wait_cnt_r == CNT_LAST)) begin
               tmo_s      = 1'b1;
               state_nx_s = ST_READY;
            end else begin
               state_nx_s = ST_RD;
            end
         end
         ST_WR: begin
            if (bus.host_wr_ready) begin
               host_we_s  = 1'b1;
               done_s     = 1'b1;
               state_nx_s = ST_READY;
            end else if ((TIMEOUT > 0) && (wait_cnt_r == CNT_LAST)) begin
               tmo_s      = 1'b1;
               state_nx_s = ST_READY;
            end else begin
               state_nx_s = ST_WR;
            end
         end
         default: begin
            state_nx_s = ST_STARTUP;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_STARTUP;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Captured transaction, round-robin pointer and wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r   <= '0;
         idx_r      <= '0;
         addr_r     <= '0;
         wdata_r    <= '0;
         wait_cnt_r <= '0;
      end else if (grab_s) begin
         rr_ptr_r   <= (win_idx_s == IDX_LAST) ? '0 : win_idx_s + 1'b1;
         idx_r      <= win_idx_s;
         addr_r     <= win_addr_s;
         wdata_r    <= win_wdata_s;
         wait_cnt_r <= '0;
      end else if (in_xfer_s) begin
         wait_cnt_r <= wait_cnt_r + 1'b1;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Response pulses land the cycle after completion or timeout; a timed-out read keeps old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_r <= '0;
         rsp_err_r   <= '0;
         rsp_data_r  <= '0;
      end else begin
         rsp_valid_r <= (done_s || tmo_s) ? onehot(idx_r) : '0;
         rsp_err_r   <= tmo_s ? onehot(idx_r) : '0;
         if (host_re_s) begin
            rsp_data_r <= bus.host_data_bus_read_in;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end
   end

   assign in_xfer_s                   = (state_r == ST_RD) || (state_r == ST_WR);
   assign bus.gnt                     = in_xfer_s ? onehot(idx_r) : '0;
   assign bus.busy                    = in_xfer_s;
   assign bus.rsp_valid               = rsp_valid_r;
   assign bus.rsp_err                 = rsp_err_r;
   assign bus.rsp_data                = rsp_data_r;
   assign bus.host_rgo                = (state_r == ST_RD);
   assign bus.host_wgo                = (state_r == ST_WR);
   assign bus.host_re                 = host_re_s;
   assign bus.host_we                 = host_we_s;
   assign bus.cpu_addr                = in_xfer_s ? 64'({addr_r, 2'b00}) : 64'd0;
   assign bus.host_data_bus_write_out = (state_r == ST_WR) ? wdata_r : '0;

endmodule

// File: tb/tb_mmu_host_arb.sv
// Directed bench for mmu_host_arb (4 clients, TIMEOUT=8): per-cycle vector table
// for round-robin and write-back, plus hand sequences for read data, timeout and reset.
module tb_mmu_host_arb;
   localparam int NR = 4;
   localparam int LW = 512;
   localparam logic [63:0] A0 = 64'h0000_0000_0000_4D10;
   localparam logic [63:0] A1 = 64'h0000_0000_0000_2AF0;
   localparam logic [63:0] A2 = 64'h0000_0000_0003_FFFC;
   localparam logic [63:0] A3 = 64'h0000_0000_0002_0004;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   mmu_host_arb_if #(.NUM_REQ(NR), .LINE_W(LW)) bus ();
   mmu_host_arb #(.NUM_REQ(NR), .LINE_W(LW), .HOST_ADDR_BITS(16), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rd, wr;
      logic        rrdy, wrdy;
      logic [3:0]  gnt, rv;
      logic        re, we, rgo, wgo, busy;
      logic [63:0] addr;
      logic        wd;
   } vec_t;

   vec_t        vecs [15];
   logic [LW-1:0] pat_a5, pat_rd, pat_wr2;
   int          re_cnt, rgo_cnt;
   logic        left_rd;

   function automatic logic [80:0] ctl();
      return {bus.gnt, bus.rsp_valid, bus.rsp_err, bus.busy, bus.host_re, bus.host_we,
              bus.host_rgo, bus.host_wgo, bus.cpu_addr};
   endfunction

   task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      pat_a5  = {64{8'hA5}};
      pat_rd  = {8{64'h1234_5678_9ABC_DEF0}};
      pat_wr2 = {16{32'hDEAD_BEEF}};
      bus.req_rd = 4'h0;
      bus.req_wr = 4'h0;
      bus.req_addr = {32'hFFFF_8001, 32'h0000_FFFF, 32'h0001_0ABC, 32'h0000_1344};
      bus.req_wr_data = '0;
      bus.req_wr_data[1*LW +: LW] = pat_a5;
      bus.host_init = 1'b0;
      bus.host_rd_ready = 1'b0;
      bus.host_wr_ready = 1'b0;
      bus.host_data_bus_read_in = '0;

      //          rd    wr    rrdy  wrdy  gnt   rv    re    we    rgo   wgo   busy  addr   wd
      vecs[0]  = '{4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[1]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, A0,    1'b0};
      vecs[2]  = '{4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[3]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, A1,    1'b0};
      vecs[4]  = '{4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[5]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, A2,    1'b0};
      vecs[6]  = '{4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[7]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, A3,    1'b0};
      vecs[8]  = '{4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[9]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, A0,    1'b0};
      vecs[10] = '{4'h2, 4'h2, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[11] = '{4'h2, 4'h2, 1'b0, 1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, A1,    1'b1};
      vecs[12] = '{4'h2, 4'h2, 1'b1, 1'b1, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, A1,    1'b1};
      vecs[13] = '{4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[14] = '{4'h2, 4'h0, 1'b0, 1'b1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, A1,    1'b0};

      // Reset values
      #1;
      chk("reset_ctl", ctl(), '0);
      chk("reset_rdata", bus.rsp_data, '0);
      chk("reset_wdata", bus.host_data_bus_write_out, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.req_rd = 4'h1;

      // Bring-up: host_init low keeps the arbiter idle
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("bringup_idle%0d", c), {bus.gnt, bus.host_rgo, bus.busy}, '0);
      end
      @(negedge clk);
      bus.host_init = 1'b1;

      // Table: round-robin 0,1,2,3,0 then write-before-read for client 1
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         bus.req_rd        = vecs[i].rd;
         bus.req_wr        = vecs[i].wr;
         bus.host_rd_ready = vecs[i].rrdy;
         bus.host_wr_ready = vecs[i].wrdy;
         #1;
         chk($sformatf("vec%0d", i),
             {ctl(), bus.host_data_bus_write_out == (vecs[i].wd ? pat_a5 : '0)},
             {vecs[i].gnt, vecs[i].rv, 4'h0, vecs[i].busy, vecs[i].re, vecs[i].we,
              vecs[i].rgo, vecs[i].wgo, vecs[i].addr, 1'b1});
      end

      // Read data return after 5 wait cycles (first wait was vec14)
      bus.host_rd_ready = 1'b0;
      bus.host_wr_ready = 1'b0;
      re_cnt = 0;
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         #1;
         re_cnt += int'(bus.host_re);
         chk($sformatf("rd_wait%0d", w), {bus.busy, bus.host_rgo, bus.gnt}, {2'b11, 4'h2});
      end
      @(negedge clk);
      bus.host_rd_ready = 1'b1;
      bus.host_data_bus_read_in = pat_rd;
      #1;
      re_cnt += int'(bus.host_re);
      chk("rd_ready_re", bus.host_re, 1'b1);
      @(negedge clk);
      bus.host_rd_ready = 1'b0;
      bus.host_data_bus_read_in = '0;
      bus.req_rd = 4'h1;
      #1;
      chk("rd_rsp", {bus.rsp_valid, bus.rsp_err, bus.busy}, {4'h2, 4'h0, 1'b0});
      chk("rd_data", bus.rsp_data, pat_rd);
      chk("rd_re_count", re_cnt, 1);

      // Timeout: client 0 read, host never ready
      rgo_cnt = 0;
      re_cnt  = 0;
      left_rd = 1'b0;
      for (int c = 0; c < 20 && !left_rd; c++) begin
         @(negedge clk);
         #1;
         if (bus.host_rgo) begin
            rgo_cnt++;
            re_cnt += int'(bus.host_re);
         end else begin
            left_rd = 1'b1;
         end
      end
      chk("tmo_cycles", rgo_cnt, 8);
      chk("tmo_no_re", re_cnt, 0);
      chk("tmo_rsp", {bus.rsp_valid, bus.rsp_err, bus.busy, bus.gnt}, {4'h1, 4'h1, 1'b0, 4'h0});
      chk("tmo_data_kept", bus.rsp_data, pat_rd);

      // Async reset three cycles into a write-back from client 2
      bus.req_rd = 4'h0;
      bus.req_wr = 4'h4;
      bus.req_wr_data[2*LW +: LW] = pat_wr2;
      @(negedge clk);
      #1;
      chk("wr2_start", {bus.gnt, bus.host_wgo, bus.rsp_valid, bus.cpu_addr}, {4'h4, 1'b1, 4'h0, A2});
      chk("wr2_data", bus.host_data_bus_write_out, pat_wr2);
      @(negedge clk);
      @(negedge clk);
      bus.req_rd = 4'h1;
      #1;
      rst = 1'b1;
      bus.host_init = 1'b0;
      #1;
      chk("midwr_rst_ctl", ctl(), '0);
      chk("midwr_rst_wdata", bus.host_data_bus_write_out, '0);
      chk("midwr_rst_rdata", bus.rsp_data, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_rst_idle%0d", c), {bus.gnt, bus.rsp_valid, bus.rsp_err, bus.busy}, '0);
      end
      @(negedge clk);
      bus.host_init = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_ready", {bus.gnt, bus.busy}, '0);
      @(negedge clk);
      #1;
      chk("post_rst_grant0", {bus.gnt, bus.host_rgo, bus.cpu_addr}, {4'h1, 1'b1, A0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mmu_host_arb.md
# mmu_host_arb

Parametrised host-memory arbiter for the MMU. It generalises the fixed two-client (I-cache/D-cache), read-only host path to NUM_REQ cache clients with round-robin arbitration, full-line write-back, a per-transaction timeout and a registered response channel. It sits between the cache miss/evict ports and the host bus (cpu_addr, host_re/we, host_rgo/wgo, 512-bit data buses).

## Interface
- NUM_REQ, 2: number of requesting clients (1..8); index 0 = I-cache, 1 = D-cache by convention
- LINE_W, 512: cache line / host data bus width in bits
- HOST_ADDR_BITS, 16: client line-address bits forwarded to the host
- TIMEOUT, 1024: max cycles waiting for host ready; 0 disables the timeout

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req_rd  in  NUM_REQ  per-client line-fill request, level, held until response
- req_wr  in  NUM_REQ  per-client line write-back request, level, held until response
- req_addr  in  NUM_REQ*32  per-client line address; client k at [32k+31:32k]
- req_wr_data  in  NUM_REQ*LINE_W  per-client write-back line
- gnt  out  NUM_REQ  one-hot; client currently in service
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted client
- rsp_err  out  NUM_REQ  one-cycle pulse with rsp_valid when the transaction timed out
- rsp_data  out  LINE_W  read line, valid in the rsp_valid cycle of a read
- busy  out  1  state is RD or WR
- host_init  in  1  host bring-up complete
- host_rd_ready  in  1  host read data valid on host_data_bus_read_in
- host_wr_ready  in  1  host accepted host_data_bus_write_out
- host_data_bus_read_in  in  LINE_W  host read data
- host_data_bus_write_out  out  LINE_W  write-back data
- cpu_addr  out  64  host address
- host_re, host_we, host_rgo, host_wgo  out  1 each  host strobes

## Operation
- States: STARTUP, READY, RD, WR. STARTUP -> READY when host_init=1; host_init is ignored afterwards.
- READY: each client is eligible if req_rd|req_wr is set. The winner is the first eligible client at or after rr_ptr, scanning upward with wrap at NUM_REQ-1 -> 0.
  - The arbiter registers the winner index, its address, its write data, and the op. If req_wr=1 the op is write, even when req_rd is also set (flush before fill).
  - Next state is WR or RD. rr_ptr <= winner+1, with wrap.
- RD: host_rgo=1; cpu_addr = zero-extended {addr_q[HOST_ADDR_BITS-1:0], 2'b00}.
  - When host_rd_ready=1: host_re=1 combinationally in that cycle; rsp_data <= host_data_bus_read_in; next state READY.
- WR: host_wgo=1; cpu_addr as in RD; host_data_bus_write_out = wdata_q.
  - When host_wr_ready=1: host_we=1 combinationally; next state READY.
- Completion: in the cycle after ready, rsp_valid[idx_q] is a one-cycle pulse, gnt drops, and the state is READY.
- Timeout (TIMEOUT>0): wait_cnt clears on entry to RD/WR and increments each cycle without ready.
  - When wait_cnt == TIMEOUT-1 with no ready: next state READY, no host_re/host_we is issued, and the next cycle pulses rsp_valid and rsp_err.
  - rsp_data is unchanged on a timed-out read.
- Request sampling happens only in READY. If a client drops its request mid-service, the transaction still completes and is still acknowledged.
- gnt = onehot(idx_q) while in RD/WR, else 0.
- host_re, host_we, host_rgo and host_wgo are 0 and cpu_addr is 0 in STARTUP and READY.
- host_data_bus_write_out = 0 outside WR.

## Timing
- Reset (async assert) values:
  - state = STARTUP; rr_ptr = 0; wait_cnt = 0.
  - gnt, rsp_valid, rsp_err, busy = 0; rsp_data = 0.
  - All host strobes = 0; cpu_addr = 0; host_data_bus_write_out = 0.
- Reset mid-transaction abandons it with no response pulse; host_init is needed again.
- Minimum read latency: request seen in READY at cycle 0 -> RD at cycle 1 -> ready at cycle 1 -> rsp_valid at cycle 2. Back-to-back grants are therefore at least 2 cycles apart.
- The arbiter spends exactly one cycle in READY between transactions, even when requests are pending.
- Host ready arriving in the first RD/WR cycle is accepted.
- Ready while in STARTUP or READY is ignored.
- host_wr_ready during RD and host_rd_ready during WR are ignored.

## Test plan
- Bring-up: hold host_init=0 for 10 cycles with req_rd[0]=1 -> no host_rgo and gnt=0. Set host_init=1 -> cpu_addr=0x0000_0000_0000_4D10 for req_addr[0]=0x0000_1344, host_rgo=1.
- Round-robin: NUM_REQ=4, all req_rd held, host_rd_ready at 1 cycle.
  - Required grant order: 0,1,2,3,0.
  - rsp_valid pulses land exactly 2 cycles apart from each grant.
- Write priority and data: client 1 asserts req_wr and req_rd with req_wr_data=pattern A5.. -> WR first, host_data_bus_write_out=A5.., host_we pulse. The following transaction is RD for client 1.
- Read data return: host_rd_ready after 5 wait cycles with data 0x1234..(512b) -> rsp_data equals it in the rsp_valid[1] cycle, rsp_err=0, host_re high for exactly 1 cycle.
- Timeout: TIMEOUT=8, never assert ready -> exactly 8 cycles in RD. No host_re is issued. Then rsp_valid[0]=rsp_err[0]=1 for 1 cycle, rsp_data unchanged, state READY.
- Async reset mid-WR: assert rst for 1 cycle, 3 cycles into WR -> all outputs 0 immediately, no rsp_valid; after host_init, the next grant starts from client 0.
